// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, framebuffer geometry and RRRGGGBB colour expansion.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_X_W    = 9;
    localparam int FB_Y_W    = 8;
    localparam int FB_ADDR_W = FB_Y_W + FB_X_W;

    localparam int CNT_W   = 10;
    localparam int PIX_W   = 8;
    localparam int COLOR_W = 10;

    typedef struct packed {
        logic vis;
        logic hs_n;
        logic vs_n;
    } vga_ctl_t;

    localparam vga_ctl_t CTL_IDLE = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

    function automatic logic [COLOR_W-1:0] expand_r(input logic [PIX_W-1:0] c);
        return {c[7:5], c[7:5], c[7:5], c[7]};
    endfunction

    function automatic logic [COLOR_W-1:0] expand_g(input logic [PIX_W-1:0] c);
        return {c[4:2], c[4:2], c[4:2], c[4]};
    endfunction

    function automatic logic [COLOR_W-1:0] expand_b(input logic [PIX_W-1:0] c);
        return {5{c[1:0]}};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical pixel counters with sync and visible-area decode.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output vga_ctl_t         ctl
);

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;

    // Next-count logic: vcnt steps only when hcnt wraps.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_en) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d = '0;
                end else begin
                    vcnt_d = vcnt_q + CNT_W'(1'b1);
                end
            end else begin
                hcnt_d = hcnt_q + CNT_W'(1'b1);
                vcnt_d = vcnt_q;
            end
        end else begin
            hcnt_d = hcnt_q;
            vcnt_d = vcnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Decode of the current counter state.
    always_comb begin
        ctl      = CTL_IDLE;
        ctl.vis  = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
        ctl.hs_n = !((hcnt_q >= H_HS_BEG) && (hcnt_q < H_HS_END));
        ctl.vs_n = !((vcnt_q >= V_VS_BEG) && (vcnt_q < V_VS_END));
    end

    assign hcnt = hcnt_q;
    assign vcnt = vcnt_q;

endmodule

// File: rtl/vga_scanout_reader.sv
// Reads a 320x240 RRRGGGBB framebuffer with 2x2 doubling and drives a 640x480 VGA DAC.
module vga_scanout_reader
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [PIX_W-1:0]     iMemReadData,
    output logic [FB_ADDR_W-1:0] oMemAddress,
    output logic                 oMemRead,
    output logic [COLOR_W-1:0]   oVGA_R,
    output logic [COLOR_W-1:0]   oVGA_G,
    output logic [COLOR_W-1:0]   oVGA_B,
    output logic                 oVGA_HS,
    output logic                 oVGA_VS,
    output logic                 oVGA_BLANK,
    output logic                 oVGA_SYNC,
    output logic                 oVGA_CLK,
    output logic                 oFrameStart
);

    logic                 toggle_q, toggle_d;
    logic                 vga_clk_q, vga_clk_d;
    logic                 pix_en_s;
    logic [CNT_W-1:0]     hcnt_s, vcnt_s;
    vga_ctl_t             ctl_s;
    vga_ctl_t             ctl1_q, ctl1_d;
    logic                 mem_read_q, mem_read_d;
    logic [FB_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic                 frame_start_q, frame_start_d;
    logic                 hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic [COLOR_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;

    assign pix_en_s = toggle_q;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (iCLK),
        .rst    (iRST),
        .pix_en (pix_en_s),
        .hcnt   (hcnt_s),
        .vcnt   (vcnt_s),
        .ctl    (ctl_s)
    );

    // Fetch on stage 1, colour capture on stage 2; memory data lands between the two ticks.
    always_comb begin
        toggle_d      = ~toggle_q;
        vga_clk_d     = toggle_q;
        mem_read_d    = 1'b0;
        mem_addr_d    = mem_addr_q;
        frame_start_d = 1'b0;
        ctl1_d        = ctl1_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        blank_d       = blank_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        if (pix_en_s) begin
            mem_read_d    = ctl_s.vis;
            frame_start_d = (hcnt_s == '0) && (vcnt_s == '0);
            if (ctl_s.vis) begin
                mem_addr_d = {vcnt_s[FB_Y_W:1], hcnt_s[FB_X_W:1]};
            end else begin
                mem_addr_d = mem_addr_q;
            end
            ctl1_d  = ctl_s;
            hs_d    = ctl1_q.hs_n;
            vs_d    = ctl1_q.vs_n;
            blank_d = ctl1_q.vis;
            if (ctl1_q.vis) begin
                r_d = expand_r(iMemReadData);
                g_d = expand_g(iMemReadData);
                b_d = expand_b(iMemReadData);
            end else begin
                r_d = '0;
                g_d = '0;
                b_d = '0;
            end
        end else begin
            mem_read_d    = 1'b0;
            frame_start_d = 1'b0;
        end
    end

    // Pixel-clock divider, fetch strobe and output pipeline registers.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            toggle_q      <= 1'b0;
            vga_clk_q     <= 1'b1;
            mem_read_q    <= 1'b0;
            mem_addr_q    <= '0;
            frame_start_q <= 1'b0;
            ctl1_q        <= CTL_IDLE;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
        end else begin
            toggle_q      <= toggle_d;
            vga_clk_q     <= vga_clk_d;
            mem_read_q    <= mem_read_d;
            mem_addr_q    <= mem_addr_d;
            frame_start_q <= frame_start_d;
            ctl1_q        <= ctl1_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
        end
    end

    assign oMemRead    = mem_read_q;
    assign oMemAddress = mem_addr_q;
    assign oFrameStart = frame_start_q;
    assign oVGA_CLK    = vga_clk_q;
    assign oVGA_HS     = hs_q;
    assign oVGA_VS     = vs_q;
    assign oVGA_BLANK  = blank_q;
    assign oVGA_R      = r_q;
    assign oVGA_G      = g_q;
    assign oVGA_B      = b_q;
    assign oVGA_SYNC   = 1'b0;

endmodule

// File: tb/tb_vga_scanout_reader.sv
// Directed bench on a reduced 28x18 raster (20x14 visible) with a small framebuffer model.
module tb_vga_scanout_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rdata = 8'h00;
    logic [16:0] mem_addr;
    logic        mem_rd;
    logic [9:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank, vga_sync, vga_clk, frame_start;

    int n_cmp = 0;
    int n_err = 0;
    int ecnt;
    int ticks;

    vga_scanout_reader #(
        .H_ACTIVE (20), .H_FP (2), .H_SYNC (4), .H_BP (2),
        .V_ACTIVE (14), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dut (
        .iCLK         (clk),
        .iRST         (rst),
        .iMemReadData (rdata),
        .oMemAddress  (mem_addr),
        .oMemRead     (mem_rd),
        .oVGA_R       (vga_r),
        .oVGA_G       (vga_g),
        .oVGA_B       (vga_b),
        .oVGA_HS      (vga_hs),
        .oVGA_VS      (vga_vs),
        .oVGA_BLANK   (vga_blank),
        .oVGA_SYNC    (vga_sync),
        .oVGA_CLK     (vga_clk),
        .oFrameStart  (frame_start)
    );

    always #10 clk = ~clk;

    // iCLK edges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    // Framebuffer: one-cycle read latency, data holds between reads.
    always @(posedge clk) begin
        if (mem_rd) begin
            if (mem_addr == {8'd5, 9'd7})      rdata <= 8'hE0;
            else if (mem_addr == {8'd1, 9'd2}) rdata <= 8'h03;
            else if (mem_addr == {8'd0, 9'd9}) rdata <= 8'hB6;
            else                               rdata <= 8'h24;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_edge(input int e);
        int guard = 0;
        while (ecnt < e && guard < 4000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (ecnt < e) begin
            n_cmp++;
            n_err++;
            $error("FAIL wait_edge: observed edge %0d expected edge %0d", ecnt, e);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd"},    32'(mem_rd),      32'd0);
        chk({tag, "_addr"},  32'(mem_addr),    32'd0);
        chk({tag, "_r"},     32'(vga_r),       32'd0);
        chk({tag, "_g"},     32'(vga_g),       32'd0);
        chk({tag, "_b"},     32'(vga_b),       32'd0);
        chk({tag, "_hs"},    32'(vga_hs),      32'd1);
        chk({tag, "_vs"},    32'(vga_vs),      32'd1);
        chk({tag, "_blank"}, 32'(vga_blank),   32'd0);
        chk({tag, "_sync"},  32'(vga_sync),    32'd0);
        chk({tag, "_fs"},    32'(frame_start), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst0");
        chk("rst0_vclk", 32'(vga_clk), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        wait_edge(2);
        chk("fs_first",   32'(frame_start), 32'd1);
        chk("rd_first",   32'(mem_rd),      32'd1);
        chk("addr_first", 32'(mem_addr),    32'd0);
        wait_edge(3);
        chk("fs_first_end", 32'(frame_start), 32'd0);
        chk("rd_single",    32'(mem_rd),      32'd0);

        // Line 0 pins: pixel h appears two pixel ticks after its counter state.
        for (int h = 0; h < 28; h++) begin
            logic       vis;
            logic [9:0] er, eb;
            vis = (h < 20);
            er  = (h == 18 || h == 19) ? 10'h2DB : (vis ? 10'h092 : 10'h000);
            eb  = (h == 18 || h == 19) ? 10'h2AA : 10'h000;
            wait_edge(2 * h + 4);
            chk("l0_blank", 32'(vga_blank), 32'(vis));
            chk("l0_r",     32'(vga_r),     32'(er));
            chk("l0_g",     32'(vga_g),     32'(er));
            chk("l0_b",     32'(vga_b),     32'(eb));
            chk("l0_hs",    32'(vga_hs),    32'((h >= 22 && h <= 25) ? 0 : 1));
            chk("l0_vs",    32'(vga_vs),    32'd1);
        end

        // Line 1 strobes: one read per visible pixel, address held in the porch.
        for (int h = 0; h < 28; h++) begin
            wait_edge(2 * (28 + h) + 2);
            chk("l1_rd",   32'(mem_rd),   32'((h < 20) ? 1 : 0));
            chk("l1_addr", 32'(mem_addr), 32'((h < 20) ? (h / 2) : 9));
            wait_edge(2 * (28 + h) + 3);
            chk("l1_rd_gap", 32'(mem_rd), 32'd0);
        end

        wait_edge(122); chk("p3v2_b", 32'(vga_b), 32'h000); chk("p3v2_r", 32'(vga_r), 32'h092);
        wait_edge(124); chk("p4v2_b", 32'(vga_b), 32'h3FF); chk("p4v2_r", 32'(vga_r), 32'h000);
                        chk("p4v2_g", 32'(vga_g), 32'h000);
        wait_edge(182); chk("p5v3_b", 32'(vga_b), 32'h3FF);
        wait_edge(184); chk("p6v3_b", 32'(vga_b), 32'h000);

        wait_edge(536); chk("p14v9_r", 32'(vga_r), 32'h092); chk("fs_mid", 32'(frame_start), 32'd0);
        wait_edge(590); chk("p13v10_r", 32'(vga_r), 32'h092);
        wait_edge(592); chk("p14v10_r", 32'(vga_r), 32'h3FF); chk("p14v10_g", 32'(vga_g), 32'h000);
                        chk("p14v10_b", 32'(vga_b), 32'h000);
        wait_edge(594); chk("p15v10_r", 32'(vga_r), 32'h3FF);
        wait_edge(650); chk("p15v11_r", 32'(vga_r), 32'h3FF);
        wait_edge(652); chk("p16v11_r", 32'(vga_r), 32'h092);
        wait_edge(704); chk("p14v12_r", 32'(vga_r), 32'h092);

        wait_edge(768); chk("max_rd", 32'(mem_rd), 32'd1);
                        chk("max_addr", 32'(mem_addr), 32'({8'd6, 9'd9}));
        wait_edge(770); chk("porch_rd", 32'(mem_rd), 32'd0);
                        chk("porch_addr", 32'(mem_addr), 32'({8'd6, 9'd9}));

        wait_edge(786); chk("v14_rd", 32'(mem_rd), 32'd0);
        wait_edge(788); chk("v14_vs", 32'(vga_vs), 32'd1); chk("v14_blank", 32'(vga_blank), 32'd0);
                        chk("v14_r", 32'(vga_r), 32'd0);
        wait_edge(844); chk("v15_vs", 32'(vga_vs), 32'd0);
        wait_edge(890); chk("v15_hs", 32'(vga_hs), 32'd0); chk("v15h23_vs", 32'(vga_vs), 32'd0);
        wait_edge(900); chk("v16_vs", 32'(vga_vs), 32'd0);
        wait_edge(956); chk("v17_vs", 32'(vga_vs), 32'd1);

        wait_edge(1010); chk("fs_frame2", 32'(frame_start), 32'd1);
                         chk("addr_frame2", 32'(mem_addr), 32'd0);
        wait_edge(1011); chk("fs_frame2_end", 32'(frame_start), 32'd0);

        // Reset in the middle of a sync pulse.
        wait_edge(1114); chk("pre_rst_hs", 32'(vga_hs), 32'd0);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst1");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        wait_edge(2); chk("fs_restart", 32'(frame_start), 32'd1);
                      chk("rd_restart", 32'(mem_rd), 32'd1);
                      chk("addr_restart", 32'(mem_addr), 32'd0);
        wait_edge(4); chk("blank_restart", 32'(vga_blank), 32'd1);
                      chk("r_restart", 32'(vga_r), 32'h092);
                      chk("hs_restart", 32'(vga_hs), 32'd1);

        ticks = 0;
        for (int i = 0; i < 56; i++) begin
            @(posedge clk);
            #1;
            if (vga_clk === 1'b0) ticks++;
        end
        chk("pix_ticks", 32'(ticks), 32'd28);

        wait_edge(102); chk("r1h21_hs", 32'(vga_hs), 32'd1);
        wait_edge(104); chk("r1h22_hs", 32'(vga_hs), 32'd0);
        wait_edge(110); chk("r1h25_hs", 32'(vga_hs), 32'd0);
        wait_edge(112); chk("r1h26_hs", 32'(vga_hs), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
